// File: rtl/alu_inst_sequencer.sv
// Purpose : multi-cycle R-type sequencer driving register-file addresses, Write_Reg and ALU_OP.
// Latency : accept at E0 -> DECODE, EXEC at E0+1, WB (Done/Write_Reg) at E0+2, ready after E0+3.
// Backpr. : Inst_Ready high only in IDLE; an instruction is taken on Inst_Valid & Inst_Ready.
//
// Ports:
//   clk, Reset (async, active-low)
//   Inst/Inst_Valid/Inst_Ready         : instruction handshake
//   R_Addr_A/R_Addr_B/W_Addr/Write_Reg : register-file control (rs, rt, rd, write enable)
//   ALU_OP                             : ALU operation select
//   ZF_In/OF_In -> ZF_Q/OF_Q           : ALU flags captured at the end of EXEC
//   Done/Illegal                       : one-cycle retire / reject pulses
//   Inst_Count                         : retired-instruction counter, wraps
// Optional feature macro: OF_TRAP_EN adds output Trap; an overflowing add/sub is not written back.
module alu_inst_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [31:0]      Inst,
    input  logic             Inst_Valid,
    output logic             Inst_Ready,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic             Write_Reg,
    output logic [2:0]       ALU_OP,
    input  logic             ZF_In,
    input  logic             OF_In,
    output logic             ZF_Q,
    output logic             OF_Q,
    output logic             Done,
    output logic             Illegal,
`ifdef OF_TRAP_EN
    output logic             Trap,
`endif
    output logic [CNT_W-1:0] Inst_Count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [31:0] ir;

    // {supported, alu_op}
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] r;
        case (funct)
            6'h24:         r = {1'b1, 3'd0};
            6'h25:         r = {1'b1, 3'd1};
            6'h26:         r = {1'b1, 3'd2};
            6'h27:         r = {1'b1, 3'd3};
            6'h20, 6'h21:  r = {1'b1, 3'd4};
            6'h22, 6'h23:  r = {1'b1, 3'd5};
            6'h2A:         r = {1'b1, 3'd6};
            6'h04:         r = {1'b1, 3'd7};
            default:       r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    logic [3:0] ir_dec;
    logic [3:0] inst_dec;
    logic       ir_illegal;
    logic       accept;

    assign ir_dec     = decode_funct(ir[5:0]);
    assign inst_dec   = decode_funct(Inst[5:0]);
    assign ir_illegal = (ir[31:26] != 6'd0) || !ir_dec[3];
    assign accept     = (state == IDLE) && Inst_Valid;

    // Register fields come straight from IR, which only changes on acceptance,
    // so they are stable from DECODE through WB.
    assign R_Addr_A = ir[25:21];
    assign R_Addr_B = ir[20:16];
    assign W_Addr   = ir[15:11];

    logic unused_shamt;
    assign unused_shamt = ^ir[10:6];

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (Inst_Valid) state_d = DECODE;
            DECODE:  state_d = ir_illegal ? IDLE : EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    logic ready_d, write_d, done_d, illegal_d, trap_d;

    always_comb begin
        trap_d = 1'b0;
`ifdef OF_TRAP_EN
        trap_d = (state == EXEC) && OF_In && ((ALU_OP == 3'd4) || (ALU_OP == 3'd5));
`endif
        ready_d   = (state_d == IDLE);
        done_d    = (state_d == WB);
        // rd = $0 is hard-wired zero, so the write is dropped rather than issued.
        write_d   = (state_d == WB) && (ir[15:11] != 5'd0) && !trap_d;
        illegal_d = (state == DECODE) && ir_illegal;
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ir         <= '0;
            ALU_OP     <= 3'd0;
            Inst_Ready <= 1'b1;
            Write_Reg  <= 1'b0;
            Done       <= 1'b0;
            Illegal    <= 1'b0;
            ZF_Q       <= 1'b0;
            OF_Q       <= 1'b0;
            Inst_Count <= '0;
`ifdef OF_TRAP_EN
            Trap       <= 1'b0;
`endif
        end else begin
            Inst_Ready <= ready_d;
            Write_Reg  <= write_d;
            Done       <= done_d;
            Illegal    <= illegal_d;
`ifdef OF_TRAP_EN
            Trap       <= trap_d;
`endif
            // ALU_OP is decoded from the incoming word so it is valid in DECODE.
            if (accept) begin
                ir     <= Inst;
                ALU_OP <= inst_dec[2:0];
            end
            if (state == EXEC) begin
                ZF_Q <= ZF_In;
                OF_Q <= OF_In;
            end
            if (state == WB) begin
                Inst_Count <= Inst_Count + 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_inst_sequencer.md
Name: alu_inst_sequencer

Overview:
Multi-cycle controller directly upstream of the register-file/ALU datapath. Accepts one 32-bit MIPS R-type instruction per valid/ready handshake, decodes it, and drives the register-file read/write addresses, Write_Reg and ALU_OP. Samples the ALU flags and retires the instruction with a one-cycle Done pulse. Non-R-type and unsupported funct codes are rejected with an Illegal pulse.

Parameters:
CNT_W, 16, width of the retired-instruction counter Inst_Count.

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous active-low reset (0 = reset)
Inst  input  32  instruction word
Inst_Valid  input  1  Inst is valid this cycle
Inst_Ready  output  1  sequencer can accept an instruction
R_Addr_A  output  5  rs field, to register-file port A
R_Addr_B  output  5  rt field, to register-file port B
W_Addr  output  5  rd field, register-file write address
Write_Reg  output  1  register-file write enable
ALU_OP  output  3  ALU operation select
ZF_In  input  1  ALU zero flag
OF_In  input  1  ALU overflow flag
ZF_Q  output  1  ZF latched for the last executed instruction
OF_Q  output  1  OF latched for the last executed instruction
Done  output  1  one-cycle retire pulse
Illegal  output  1  one-cycle reject pulse
Inst_Count  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset low, asynchronous: state = IDLE; IR = 0; all outputs 0 except Inst_Ready = 1 (IDLE); Inst_Count = 0. Reset asserted mid-instruction aborts it with no write.
- FSM states: IDLE, DECODE, EXEC, WB. All outputs are registered.
- IDLE: Inst_Ready = 1. On Inst_Valid = 1 at a rising edge, latch Inst into IR and go to DECODE. Inst_Ready = 0 in every other state.
- DECODE:
  - R_Addr_A = IR[25:21], R_Addr_B = IR[20:16], W_Addr = IR[15:11].
  - ALU_OP comes from funct IR[5:0]: 0x24→0, 0x25→1, 0x26→2, 0x27→3, 0x20/0x21→4, 0x22/0x23→5, 0x2A→6, 0x04→7.
  - If IR[31:26] ≠ 0 or funct is unmapped: Illegal = 1 for one cycle (on entering IDLE), return to IDLE, no write, count unchanged.
  - Otherwise go to EXEC.
- Address and ALU_OP outputs stay stable from DECODE through WB.
- EXEC: one cycle for the combinational ALU to settle. At the end of EXEC, latch ZF_In→ZF_Q and OF_In→OF_Q, then go to WB.
- WB:
  - Write_Reg = 1 for exactly this cycle, unless W_Addr = 0, in which case the write is suppressed.
  - Done = 1 for this cycle. Inst_Count increments on leaving WB. Next state is IDLE.
- Latency: acceptance edge E0 gives DECODE after E0, EXEC after E0+1, and WB (Write_Reg/Done) after E0+2. Ready again after E0+3, so throughput is 1 instruction per 4 cycles.
- Write_Reg is 0 in every state other than WB.
- Done and Illegal are never asserted together.
- ZF_Q and OF_Q hold their values until the next EXEC. An illegal instruction does not update them.

Optional Feature:
OF_TRAP_EN
- Defined: for ALU_OP 4/5, OF_In = 1 at the end of EXEC suppresses the WB write. Output Trap (1 bit) pulses in the WB cycle; Done still pulses and Inst_Count still increments.
- Undefined: no Trap port, and overflowing results are written normally.

Test Plan:
1. Reset low for 2 cycles, then release → Inst_Ready = 1, Write_Reg = 0, Inst_Count = 0, ZF_Q = OF_Q = 0.
2. Inst = 0x00221820 (add $3,$1,$2) accepted at E0 → R_Addr_A = 1, R_Addr_B = 2, W_Addr = 3, ALU_OP = 4. Write_Reg = Done = 1 in the cycle after E0+2 only. Inst_Count = 1.
3. Inst = 0x8C220000 (lw) → Illegal pulses once, Write_Reg never 1, Inst_Count unchanged, Inst_Ready = 1 two cycles after acceptance.
4. Inst = 0x00220024 (and $0,$1,$2) with ZF_In = 1 during EXEC → Done = 1, Write_Reg stays 0, ZF_Q = 1, Inst_Count increments.
5. Inst_Valid held high with 0x00221822 then 0x00221804 → acceptances exactly 4 cycles apart. ALU_OP = 5, then 7.
6. Reset driven low during EXEC of an add → immediate IDLE, Write_Reg never asserted. With OF_TRAP_EN defined: add with OF_In = 1 → Trap = 1, Write_Reg = 0, Done = 1.
